// File: rtl/mandel_pkg.sv
// Shared state encoding, fixed-point defaults and BRAM address packing for the Mandelbrot writer.
package mandel_pkg;

  typedef enum logic [2:0] {IDLE, INIT, ITER, WRITE, DONE} state_t;

  localparam int DEF_DW    = 32;
  localparam int DEF_FW    = 28;
  localparam int DEF_X_MIN = -671088640;  // -2.5
  localparam int DEF_Y_MAX = 352321536;   // +1.3125
  localparam int DEF_STEP  = 1468006;     // 3.5/640
  localparam int AW        = 19;

  localparam logic signed [DEF_DW+1:0] FOUR = 34'sd4 <<< DEF_FW;

  function automatic logic [AW-1:0] pack_addr(input logic [9:0] x, input logic [8:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/mandel_iter_step.sv
// One z <- z^2 + c step in signed Q4.(DW-4), plus the |z|^2 >= 4 escape test on the incoming z.
module mandel_iter_step
  import mandel_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int FW = DEF_FW
) (
  input  logic signed [DW-1:0] zr_i,
  input  logic signed [DW-1:0] zi_i,
  input  logic signed [DW-1:0] cr_i,
  input  logic signed [DW-1:0] ci_i,
  output logic signed [DW-1:0] zr_n_o,
  output logic signed [DW-1:0] zi_n_o,
  output logic                 escape_o
);

  localparam logic signed [DW+1:0] FOUR_L = (DW+2)'(FOUR >>> DEF_FW) << FW;

  logic signed [2*DW-1:0] zr2_full, zi2_full, zrzi_full;
  logic signed [DW+1:0]   zr2, zi2, zrzi, mag;

  assign zr2_full  = zr_i * zr_i;
  assign zi2_full  = zi_i * zi_i;
  assign zrzi_full = zr_i * zi_i;

  // Products are kept at DW+2 bits so the magnitude test has headroom above 4.0.
  assign zr2  = (DW+2)'(zr2_full >>> FW);
  assign zi2  = (DW+2)'(zi2_full >>> FW);
  assign zrzi = (DW+2)'(zrzi_full >>> FW);
  assign mag  = zr2 + zi2;

  assign escape_o = (mag >= FOUR_L);
  assign zr_n_o   = DW'(zr2 - zi2) + cr_i;
  assign zi_n_o   = DW'(zrzi <<< 1) + ci_i;

endmodule

// File: rtl/mandel_frame_writer.sv
// Walks an H_RES x V_RES raster, iterates z <- z^2 + c per pixel and writes the 7-bit escape count to BRAM.
// Define MANDEL_RUNTIME_VIEW_EN to take the view window (xmin/ymax/step) from ports, latched on start.
module mandel_frame_writer
  import mandel_pkg::*;
#(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int DW       = DEF_DW,
  parameter int FW       = DEF_FW,
  parameter int MAX_ITER = 127,
  parameter logic signed [DW-1:0] X_MIN = DW'(DEF_X_MIN),
  parameter logic signed [DW-1:0] Y_MAX = DW'(DEF_Y_MAX),
  parameter logic signed [DW-1:0] STEP  = DW'(DEF_STEP)
) (
  input  logic          CLK_100MHz,
  input  logic          reset,
  input  logic          start,
`ifdef MANDEL_RUNTIME_VIEW_EN
  input  logic [DW-1:0] view_xmin,
  input  logic [DW-1:0] view_ymax,
  input  logic [DW-1:0] view_step,
`endif
  output logic          busy,
  output logic          done,
  output logic          wea,
  output logic [AW-1:0] addr_w,
  output logic [6:0]    dina
);

  localparam logic [9:0] X_LAST   = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST   = 9'(V_RES - 1);
  localparam logic [6:0] ITER_CAP = 7'(MAX_ITER);

  state_t               state_q;
  logic [9:0]           x_q;
  logic [8:0]           y_q;
  logic signed [DW-1:0] cr_q, ci_q, zr_q, zi_q;
  logic signed [DW-1:0] zr_d, zi_d;
  logic [6:0]           iter_q;
  logic                 busy_q, done_q, wea_q;
  logic [AW-1:0]        addr_q;
  logic [6:0]           dina_q;
  logic                 escape;

  // frame_* seed the first pixel of a frame; row_xmin/col_step drive the incremental walk.
  logic signed [DW-1:0] frame_xmin, frame_ymax, row_xmin, col_step;

`ifdef MANDEL_RUNTIME_VIEW_EN
  logic signed [DW-1:0] xmin_q, step_q;
  logic                 start_ok;

  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign frame_xmin = view_xmin;
  assign frame_ymax = view_ymax;
  assign row_xmin   = xmin_q;
  assign col_step   = step_q;

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      xmin_q <= X_MIN;
      step_q <= STEP;
    end else if (start_ok) begin
      xmin_q <= view_xmin;
      step_q <= view_step;
    end
  end
`else
  assign frame_xmin = X_MIN;
  assign frame_ymax = Y_MAX;
  assign row_xmin   = X_MIN;
  assign col_step   = STEP;
`endif

  mandel_iter_step #(.DW(DW), .FW(FW)) u_step (
    .zr_i     (zr_q),
    .zi_i     (zi_q),
    .cr_i     (cr_q),
    .ci_i     (ci_q),
    .zr_n_o   (zr_d),
    .zi_n_o   (zi_d),
    .escape_o (escape)
  );

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cr_q    <= X_MIN;
      ci_q    <= Y_MAX;
      zr_q    <= '0;
      zi_q    <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wea_q   <= 1'b0;
      addr_q  <= '0;
      dina_q  <= '0;
    end else begin
      done_q <= 1'b0;
      wea_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= INIT;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            cr_q    <= frame_xmin;
            ci_q    <= frame_ymax;
          end
        end
        INIT: begin
          zr_q    <= '0;
          zi_q    <= '0;
          iter_q  <= '0;
          state_q <= ITER;
        end
        ITER: begin
          if (escape || iter_q == ITER_CAP) begin
            state_q <= WRITE;
            wea_q   <= 1'b1;
            addr_q  <= pack_addr(x_q, y_q);
            dina_q  <= iter_q;
          end else begin
            zr_q   <= zr_d;
            zi_q   <= zi_d;
            iter_q <= iter_q + 7'd1;
          end
        end
        WRITE: begin
          if (x_q < X_LAST) begin
            x_q     <= x_q + 10'd1;
            cr_q    <= cr_q + col_step;
            state_q <= INIT;
          end else if (y_q < Y_LAST) begin
            x_q     <= '0;
            cr_q    <= row_xmin;
            y_q     <= y_q + 9'd1;
            ci_q    <= ci_q - col_step;
            state_q <= INIT;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign wea    = wea_q;
  assign addr_w = addr_q;
  assign dina   = dina_q;

endmodule

// File: tb/tb_mandel_frame_writer.sv
// Bench: a full-size default instance, a 4x2 instance at c=0 and an 8x4 window instance, all checked
// against an escape-time reference model; MANDEL_RUNTIME_VIEW_EN adds the runtime-view scenarios.
`timescale 1ns/1ps
module tb_mandel_frame_writer;

  localparam int XA = -671088640, YA = 352321536, SA = 1468006;
  localparam int XC = -536870912, YC = 301989888, SC = 100663296;

  typedef struct {int addr; int dat; int cyc;} wr_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, start_a, busy_a, done_a, wea_a;
  logic rst_b, start_b, busy_b, done_b, wea_b;
  logic rst_c, start_c, busy_c, done_c, wea_c;
  logic [18:0] addr_a, addr_b, addr_c;
  logic [6:0]  dina_a, dina_b, dina_c;
`ifdef MANDEL_RUNTIME_VIEW_EN
  logic [31:0] vx_a, vy_a, vs_a, vx_b, vy_b, vs_b, vx_c, vy_c, vs_c;
`endif

  mandel_frame_writer u_a (
    .CLK_100MHz(clk), .reset(rst_a), .start(start_a),
`ifdef MANDEL_RUNTIME_VIEW_EN
    .view_xmin(vx_a), .view_ymax(vy_a), .view_step(vs_a),
`endif
    .busy(busy_a), .done(done_a), .wea(wea_a), .addr_w(addr_a), .dina(dina_a));

  mandel_frame_writer #(.H_RES(4), .V_RES(2), .X_MIN(32'sd0), .Y_MAX(32'sd0), .STEP(32'sd0)) u_b (
    .CLK_100MHz(clk), .reset(rst_b), .start(start_b),
`ifdef MANDEL_RUNTIME_VIEW_EN
    .view_xmin(vx_b), .view_ymax(vy_b), .view_step(vs_b),
`endif
    .busy(busy_b), .done(done_b), .wea(wea_b), .addr_w(addr_b), .dina(dina_b));

  mandel_frame_writer #(.H_RES(8), .V_RES(4), .X_MIN(XC), .Y_MAX(YC), .STEP(SC)) u_c (
    .CLK_100MHz(clk), .reset(rst_c), .start(start_c),
`ifdef MANDEL_RUNTIME_VIEW_EN
    .view_xmin(vx_c), .view_ymax(vy_c), .view_step(vs_c),
`endif
    .busy(busy_c), .done(done_c), .wea(wea_c), .addr_w(addr_c), .dina(dina_c));

  wr_t qa[$], qb[$], qc[$];
  int  nd_a = 0, nd_b = 0, nd_c = 0, dcyc_b = 0;

  always @(negedge clk) begin
    if (wea_a === 1'b1) qa.push_back('{int'(addr_a), int'(dina_a), cyc});
    if (wea_b === 1'b1) qb.push_back('{int'(addr_b), int'(dina_b), cyc});
    if (wea_c === 1'b1) qc.push_back('{int'(addr_c), int'(dina_c), cyc});
    if (done_a === 1'b1) nd_a++;
    if (done_b === 1'b1) begin nd_b++; dcyc_b = cyc; end
    if (done_c === 1'b1) nd_c++;
  end

  // ---------------- reference model ----------------
  function automatic longint sx34(input longint v);
    logic signed [33:0] t;
    t = v[33:0];
    return longint'(t);
  endfunction

  function automatic longint sx32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic int esc_count(input longint cr, input longint ci);
    longint zr, zi, a, b, p;
    zr = 0;
    zi = 0;
    for (int it = 0; it <= 127; it++) begin
      a = sx34((zr * zr) >>> 28);
      b = sx34((zi * zi) >>> 28);
      p = sx34((zr * zi) >>> 28);
      if (sx34(a + b) >= 64'sd4 * 64'sd268435456 || it == 127) return it;
      zr = sx32(a - b + cr);
      zi = sx32(2 * p + ci);
    end
    return 127;
  endfunction

  function automatic int exp_dat(input int xmin, input int ymax, input int step, input int x, input int y);
    logic signed [31:0] cr, ci;
    cr = xmin + x * step;
    ci = ymax - y * step;
    return esc_count(longint'(cr), longint'(ci));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
`ifdef MANDEL_RUNTIME_VIEW_EN
    vx_a = XA; vy_a = YA; vs_a = SA;
    vx_b = 0;  vy_b = 0;  vs_b = 0;
    vx_c = XC; vy_c = YC; vs_c = SC;
`endif
    tick(3);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_a); end
    total++; if (wea_a !== 1'b0) begin bad++; $display("FAIL rst_wea got=%b want=0", wea_a); end
    total++; if (addr_a !== 19'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", addr_a); end
    total++; if (dina_a !== 7'd0) begin bad++; $display("FAIL rst_dina got=%0d want=0", dina_a); end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick(20);
    total++; if (qa.size() + qb.size() + qc.size() != 0)
      begin bad++; $display("FAIL idle_no_write got=%0d writes want=0", qa.size() + qb.size() + qc.size()); end
  endtask

  // Leaves u_a in the INIT cycle right after its n-th write.
  task automatic test_default_frame;
    int n, c0, ex;
    qa.delete();
    tick($urandom_range(1, 10));
    start_a = 1'b1; tick(1); start_a = 1'b0;
    c0 = cyc;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL a_busy_after_start got=%b want=1", busy_a); end
    n = $urandom_range(12, 30);
    for (int i = 0; i < 4000 && qa.size() < n; i++) tick(1);
    total++; if (qa.size() < n) begin bad++; $display("FAIL a_write_timeout got=%0d want=%0d", qa.size(), n); end
    if (qa.size() > 0) begin
      total++; if (qa[0].addr != 0 || qa[0].dat != 1)
        begin bad++; $display("FAIL a_first_write got=%0d/%0d want=0/1", qa[0].addr, qa[0].dat); end
      total++; if (qa[0].cyc != c0 + 3)
        begin bad++; $display("FAIL a_first_latency got=%0d want=%0d", qa[0].cyc - c0, 3); end
    end
    for (int i = 1; i < qa.size(); i++) begin
      ex = exp_dat(XA, YA, SA, i, 0);
      total++; if (qa[i].addr != i || qa[i].dat != ex)
        begin bad++; $display("FAIL a_pix%0d got=%0d/%0d want=%0d/%0d", i, qa[i].addr, qa[i].dat, i, ex); end
      total++; if (qa[i].cyc - qa[i-1].cyc != ex + 3)
        begin bad++; $display("FAIL a_gap%0d got=%0d want=%0d", i, qa[i].cyc - qa[i-1].cyc, ex + 3); end
    end
  endtask

  task automatic test_reset_mid_iter;
    int d0;
    d0 = nd_a;
    tick(1);
    #1 rst_a = 1'b1;
    #1;
    total++; if ({busy_a, done_a, wea_a} !== 3'b000)
      begin bad++; $display("FAIL mid_rst_ctl got=%b want=000", {busy_a, done_a, wea_a}); end
    total++; if (addr_a !== 19'd0 || dina_a !== 7'd0)
      begin bad++; $display("FAIL mid_rst_data got=%0d/%0d want=0/0", addr_a, dina_a); end
    tick(2);
    rst_a = 1'b0;
    qa.delete();
    tick(300);
    total++; if (qa.size() != 0 || busy_a !== 1'b0)
      begin bad++; $display("FAIL post_rst_idle got=%0d/%b want=0/0", qa.size(), busy_a); end
    total++; if (nd_a != d0) begin bad++; $display("FAIL post_rst_done got=%0d want=0", nd_a - d0); end
  endtask

  // hold: 0 single start pulse; 1 start held and re-pulsed while busy
  task automatic test_small_frame(input int hold);
    int c0, d0, wa;
    qb.delete();
    d0 = nd_b;
    tick($urandom_range(1, 8));
    start_b = 1'b1; tick(1);
    c0 = cyc;
    if (hold != 0) begin
      tick($urandom_range(100, 300));
      for (int i = 0; i < 500; i++) begin
        start_b = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    start_b = 1'b0;
    for (int i = 0; i < 2000 && nd_b == d0; i++) tick(1);
    tick(20);
    total++; if (nd_b - d0 != 1) begin bad++; $display("FAIL b_done_count got=%0d want=1", nd_b - d0); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL b_busy_after got=%b want=0", busy_b); end
    total++; if (qb.size() != 8) begin bad++; $display("FAIL b_write_count got=%0d want=8", qb.size()); end
    for (int i = 0; i < qb.size() && i < 8; i++) begin
      wa = (i / 4) * 1024 + (i % 4);
      total++; if (qb[i].addr != wa || qb[i].dat != 127 || qb[i].cyc != c0 + 129 + 130 * i)
        begin bad++; $display("FAIL b_wr%0d got=%0d/%0d@%0d want=%0d/127@%0d", i, qb[i].addr, qb[i].dat,
                              qb[i].cyc - c0, wa, 129 + 130 * i); end
    end
    total++; if (dcyc_b != c0 + 129 + 130 * 7 + 1)
      begin bad++; $display("FAIL b_done_cycle got=%0d want=%0d", dcyc_b - c0, 129 + 130 * 7 + 1); end
  endtask

  task automatic run_c_frame(input int xm, input int ym, input int st, input int chg);
    int c0, d0, ex;
    qc.delete();
    d0 = nd_c;
`ifdef MANDEL_RUNTIME_VIEW_EN
    vx_c = xm; vy_c = ym; vs_c = st;
`endif
    tick($urandom_range(1, 8));
    start_c = 1'b1; tick(1); start_c = 1'b0;
    c0 = cyc;
    if (chg != 0) begin
      for (int i = 0; i < 2000 && qc.size() < 5; i++) tick(1);
`ifdef MANDEL_RUNTIME_VIEW_EN
      vx_c = $urandom; vy_c = $urandom; vs_c = $urandom;
`endif
    end
    for (int i = 0; i < 5000 && nd_c == d0; i++) tick(1);
    tick(5);
    total++; if (qc.size() != 32 || nd_c - d0 != 1)
      begin bad++; $display("FAIL c_frame got=%0d writes/%0d done want=32/1", qc.size(), nd_c - d0); end
    for (int i = 0; i < qc.size() && i < 32; i++) begin
      ex = exp_dat(xm, ym, st, i % 8, i / 8);
      total++; if (qc[i].addr != (i / 8) * 1024 + (i % 8) || qc[i].dat != ex)
        begin bad++; $display("FAIL c_pix%0d got=%0d/%0d want=%0d/%0d", i, qc[i].addr, qc[i].dat,
                              (i / 8) * 1024 + (i % 8), ex); end
      total++; if ((i == 0 && qc[0].cyc != c0 + ex + 2) || (i > 0 && qc[i].cyc - qc[i-1].cyc != ex + 3))
        begin bad++; $display("FAIL c_timing%0d got=%0d want=%0d", i, qc[i].cyc - c0, ex); end
    end
  endtask

  task automatic test_model_frame;
    run_c_frame(XC, YC, SC, 0);
  endtask

`ifdef MANDEL_RUNTIME_VIEW_EN
  task automatic test_view_escape;
    int d0;
    qb.delete();
    d0 = nd_b;
    vx_b = 32'd536870912; vy_b = $urandom_range(0, 268435456); vs_b = 0;
    start_b = 1'b1; tick(1); start_b = 1'b0;
    vx_b = 0; vy_b = 0;
    for (int i = 0; i < 500 && nd_b == d0; i++) tick(1);
    total++; if (qb.size() != 8) begin bad++; $display("FAIL view_esc_count got=%0d want=8", qb.size()); end
    for (int i = 0; i < qb.size(); i++) begin
      total++; if (qb[i].dat != 1) begin bad++; $display("FAIL view_esc_pix%0d got=%0d want=1", i, qb[i].dat); end
    end
  endtask

  task automatic test_view_random;
    int xm, ym, st;
    for (int k = 0; k < 2; k++) begin
      xm = -536870912 + int'($urandom_range(0, 268435456));
      ym = int'($urandom_range(0, 322122547));
      st = int'($urandom_range(26843545, 107374182));
      run_c_frame(xm, ym, st, k);
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_frame();
    test_reset_mid_iter();
    test_small_frame(0);
    test_small_frame(1);
    test_small_frame(0);
    test_model_frame();
`ifdef MANDEL_RUNTIME_VIEW_EN
    test_view_escape();
    test_view_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
